systolic_ctrl: RTL
==================

Name: systolic_ctrl

Overview:
- Sequencer for an N×N weight-stationary systolic array of bf16-multiply / fp32-accumulate PEs.
- Buffers one N×N weight tile and shifts it into the array with arr_mode=0, then switches to arr_mode=1.
- Streams activation vectors into the left edge with per-row skew, feeds zero partial sums at the top edge, and de-skews bottom-edge results into one aligned result vector per input vector.
- Sits between the DMA/stream front end and the PE grid.

Parameters:
- N, 4: array rows/columns.
- MUL_BW, 16: bf16 operand width (weights, activations).
- ADD_BW, 32: fp32 partial-sum/result width.
- ACC_LAT, 0: extra pipeline cycles per PE on the vertical (sum) path. Per-row hop latency is H = 1 + ACC_LAT.
- CNT_W, 16: width of the vector-count config.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high (already decided).
- start  in  1  one-cycle job start; ignored while busy.
- reuse_w  in  1  sampled with start; 1 skips weight load and keeps the weights already in the array.
- num_vec  in  CNT_W  activation vectors in the job; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.
- w_valid  in  1  weight row valid.
- w_ready  out  1  weight row accept.
- w_data  in  N*MUL_BW  one weight row, column j at bits [j*MUL_BW +: MUL_BW].
- a_valid  in  1  activation vector valid.
- a_ready  out  1  activation accept.
- a_data  in  N*MUL_BW  activation vector, element r destined for array row r.
- arr_mode  out  1  PE mode: 0 = weight shift, 1 = compute.
- arr_top  out  N*ADD_BW  top-edge inputs, one per column.
- arr_left  out  N*MUL_BW  left-edge inputs, one per row.
- arr_bot  in  N*ADD_BW  bottom-edge outputs of row N-1.
- res_valid  out  1  result vector valid; one-cycle pulse, no backpressure.
- res_data  out  N*ADD_BW  aligned results, column j in slice j.

Behaviour:
- Reset values: busy=0, done=0, w_ready=0, a_ready=0, arr_mode=0, arr_top=0, arr_left=0, res_valid=0, res_data=0. Skew lines, de-skew lines, valid pipeline, weight buffer and counters all clear. rst mid-job aborts to IDLE immediately; no done is issued. rst also clears PE weights, so a later reuse_w=1 job computes with zero weights.
- All array-facing outputs (arr_mode, arr_top, arr_left) and res_* are registered.
- FSM states: IDLE, WFILL, WSHIFT, STREAM, DRAIN, FIN.
- IDLE: on start, latch num_vec and go to:
  - WFILL if reuse_w=0;
  - STREAM if reuse_w=1 and num_vec≠0;
  - FIN otherwise.
- WFILL:
  - w_ready=1; rows are accepted on w_valid&w_ready into buffer entries 0..N-1, with gaps allowed.
  - Row r is the weight row for array row r.
  - After the N-th accept, go to WSHIFT.
- WSHIFT:
  - Runs exactly N consecutive cycles with arr_mode=0.
  - Cycle k drives buffer row N-1-k on arr_top: the low MUL_BW bits of each slice carry the weight, the upper bits are zero.
  - After the N-th cycle, arr_mode=1 and arr_top=0 from the next cycle on.
  - Next state is STREAM if num_vec≠0, else FIN.
- STREAM:
  - a_ready=1; arr_mode=1; arr_top=0.
  - A vector accepted at cycle t places element r on arr_left row r at cycle t+1+r*H, via per-row delay lines.
  - Cycles with no accept inject zeros and a 0 valid bit.
  - After num_vec accepts, a_ready=0 and go to DRAIN.
- DRAIN: wait until the valid pipeline is empty, then go to FIN.
- FIN: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Latency: column j from bottom row is delayed N-1-j cycles to de-skew. res_valid and res_data for a vector accepted at t appear at t+L, with L = N*(H+1). Result order equals input order.
- The valid pipeline has depth L. res_valid is asserted only for accepted vectors, never for bubbles.
- A start while busy is ignored; job config is not re-sampled.
- arr_left and arr_top hold 0 outside WSHIFT and STREAM, except activation elements already in skew lines continue to drain.
- No arithmetic inside the block; data widths pass through unchanged.

Test Plan:
- Identity load then compute: N=2, H=1, W=[[3F80,0000],[0000,3F80]], one vector a=[3F80,4000] accepted at cycle t. Required: res_valid only at t+4, res_data=[3F800000,40000000], then done one cycle later.
- WSHIFT ordering: W rows [0x1111,0x2222],[0x3333,0x4444]. Required: arr_top low halves are [3333,4444] then [1111,2222] on consecutive cycles with arr_mode=0, then arr_mode=1.
- Bubbles: N=2, num_vec=3, a_valid pattern 1,0,1,0,1 with a=[4000,0000],[0000,4000],[4000,4000] and identity W. Required: three res_valid pulses spaced 2 cycles, values [40000000,0],[0,40000000],[40000000,40000000].
- reuse_w=1 second job with num_vec=1 and a=[3F80,3F80]. Required: no w_ready, no WSHIFT, result [3F800000,3F800000].
- num_vec=0, reuse_w=0. Required: N weight accepts, N-cycle shift, then done with no res_valid.
- rst asserted in STREAM after 1 of 3 accepts. Required: next cycle all outputs are at reset values, no done, no res_valid. A following start runs normally.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Controller-side bundle: job control, weight/activation streams, PE-grid edges and results.
// slave = sequencer, master = front end plus array (as seen from a bench or wrapper).
interface systolic_ctrl_if #(
    parameter int N      = 4,
    parameter int MUL_BW = 16,
    parameter int ADD_BW = 32,
    parameter int CNT_W  = 16
);
    logic                  start;
    logic                  reuse_w;
    logic [CNT_W-1:0]      num_vec;
    logic                  busy;
    logic                  done;
    logic                  w_valid;
    logic                  w_ready;
    logic [N*MUL_BW-1:0]   w_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [N*MUL_BW-1:0]   a_data;
    logic                  arr_mode;
    logic [N*ADD_BW-1:0]   arr_top;
    logic [N*MUL_BW-1:0]   arr_left;
    logic [N*ADD_BW-1:0]   arr_bot;
    logic                  res_valid;
    logic [N*ADD_BW-1:0]   res_data;

    modport slave (
        input  start, reuse_w, num_vec, w_valid, w_data, a_valid, a_data, arr_bot,
        output busy, done, w_ready, a_ready, arr_mode, arr_top, arr_left, res_valid, res_data
    );

    modport master (
        output start, reuse_w, num_vec, w_valid, w_data, a_valid, a_data, arr_bot,
        input  busy, done, w_ready, a_ready, arr_mode, arr_top, arr_left, res_valid, res_data
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: weight load/shift, skewed activation feed, result de-skew.
// Result latency N*(2+ACC_LAT) after accept; w/a ready only in their phases, results carry no backpressure.
module systolic_ctrl #(
    parameter int N       = 4,
    parameter int MUL_BW  = 16,
    parameter int ADD_BW  = 32,
    parameter int ACC_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    systolic_ctrl_if.slave bus
);
    localparam int H  = 1 + ACC_LAT;
    localparam int L  = N * (H + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

    typedef enum logic [2:0] {IDLE, WFILL, WSHIFT, STREAM, DRAIN, FIN} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    vec_cfg, vec_cnt;
    logic [RW-1:0]       row_cnt;
    logic [N*MUL_BW-1:0] wbuf [N];
    logic [N*MUL_BW-1:0] wrow;
    logic [L-1:0]        vpipe;
    logic                w_rdy, a_rdy, busy_c, done_c;
    logic                w_acc, a_acc, row_last, vec_last;
    logic                mode_q;
    logic [N*ADD_BW-1:0] top_q, top_nxt, res_q;
    logic [MUL_BW-1:0]   left_row [N];
    logic [ADD_BW-1:0]   col_out [N];

    assign w_acc    = bus.w_valid & w_rdy;
    assign a_acc    = bus.a_valid & a_rdy;
    assign row_last = (row_cnt == ROW_LAST);
    assign vec_last = (vec_cnt == vec_cfg - 1'b1);

    always_comb begin
        state_nxt = state;
        w_rdy     = 1'b0;
        a_rdy     = 1'b0;
        done_c    = 1'b0;
        busy_c    = (state != IDLE);
        case (state)
            IDLE: if (bus.start) begin
                if (!bus.reuse_w)             state_nxt = WFILL;
                else if (bus.num_vec != '0)   state_nxt = STREAM;
                else                          state_nxt = FIN;
            end
            WFILL: begin
                w_rdy = 1'b1;
                if (bus.w_valid && row_last) state_nxt = WSHIFT;
            end
            WSHIFT: if (row_last) state_nxt = (vec_cfg != '0) ? STREAM : FIN;
            STREAM: begin
                a_rdy = 1'b1;
                if (bus.a_valid && vec_last) state_nxt = DRAIN;
            end
            // Leave once only the vector at the output stage remains, so done lands right after it.
            DRAIN: if (vpipe[L-2:0] == '0) state_nxt = FIN;
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            vec_cfg <= '0;
            vec_cnt <= '0;
            row_cnt <= '0;
            vpipe   <= '0;
            for (int i = 0; i < N; i++) wbuf[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                vec_cfg <= bus.num_vec;
                vec_cnt <= '0;
            end
            if (w_acc) wbuf[row_cnt] <= bus.w_data;
            if (w_acc || state == WSHIFT) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            if (a_acc) vec_cnt <= vec_cnt + 1'b1;
            vpipe <= {vpipe[L-2:0], a_acc};
        end
    end

    // Bottom row enters first: cycle k of the shift pushes buffer row N-1-k.
    always_comb begin
        top_nxt = '0;
        wrow    = wbuf[ROW_LAST - row_cnt];
        if (state == WSHIFT)
            for (int j = 0; j < N; j++)
                top_nxt[j*ADD_BW +: ADD_BW] = {{(ADD_BW-MUL_BW){1'b0}}, wrow[j*MUL_BW +: MUL_BW]};
    end

    // Mode holds across IDLE/WFILL so loaded weights stay put for reuse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            top_q  <= '0;
        end else begin
            if (state == WSHIFT)                          mode_q <= 1'b0;
            else if (state inside {STREAM, DRAIN, FIN})   mode_q <= 1'b1;
            top_q <= top_nxt;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        localparam int D = r * H + 1;
        logic [MUL_BW-1:0] sk [D];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < D; k++) sk[k] <= '0;
            end else begin
                sk[0] <= a_acc ? bus.a_data[r*MUL_BW +: MUL_BW] : '0;
                for (int k = 1; k < D; k++) sk[k] <= sk[k-1];
            end
        end
        assign left_row[r] = sk[D-1];
    end

    for (genvar j = 0; j < N; j++) begin : g_dsk
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_thru
            assign col_out[j] = bus.arr_bot[j*ADD_BW +: ADD_BW];
        end else begin : g_dl
            logic [ADD_BW-1:0] dl [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dl[k] <= '0;
                end else begin
                    dl[0] <= bus.arr_bot[j*ADD_BW +: ADD_BW];
                    for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
                end
            end
            assign col_out[j] = dl[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (vpipe[L-2]) begin
            for (int j = 0; j < N; j++) res_q[j*ADD_BW +: ADD_BW] <= col_out[j];
        end
    end

    always_comb begin
        bus.arr_left = '0;
        for (int r = 0; r < N; r++) bus.arr_left[r*MUL_BW +: MUL_BW] = left_row[r];
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.w_ready   = w_rdy;
    assign bus.a_ready   = a_rdy;
    assign bus.arr_mode  = mode_q;
    assign bus.arr_top   = top_q;
    assign bus.res_valid = vpipe[L-1];
    assign bus.res_data  = res_q;
endmodule
